// File: rtl/imem_pkg.sv
// Shared types and helpers for the streamed instruction memory.
package imem_pkg;

    // Loader states: empty, filling from the stream, filled and fetchable.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } imem_state_e;

    // Reasons a fetch is rejected, in priority order (state first).
    localparam logic [1:0] ERR_CAUSE_NONE  = 2'd0;
    localparam logic [1:0] ERR_CAUSE_STATE = 2'd1;
    localparam logic [1:0] ERR_CAUSE_ALIGN = 2'd2;
    localparam logic [1:0] ERR_CAUSE_RANGE = 2'd3;

    // Number of byte-address bits that select a byte inside one word.
    function automatic int unsigned byte_shift(input int unsigned data_w);
        return $clog2(data_w / 32'd8);
    endfunction

endpackage

// File: rtl/imem_ram.sv
// DEPTH x DATA_W storage: one write port, one registered read port.
// The read register only updates on a read so the last word is held.
module imem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Next read data: new word on a read, otherwise hold.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read data register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= {DATA_W{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/imem_stream_loader.sv
// Instruction memory filled from a valid/ready word stream, then serving
// registered, alignment- and range-checked fetches by byte address.
module imem_stream_loader
    import imem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_start,
    input  logic                         load_valid,
    input  logic [DATA_W-1:0]            load_data,
    input  logic                         load_last,
    output logic                         load_ready,
    output logic                         load_done,
    output logic                         load_overflow,
    output logic [$clog2(DEPTH+1)-1:0]   loaded_words,
    input  logic                         fetch_en,
    input  logic [ADDR_W-1:0]            fetch_addr,
    output logic                         fetch_valid,
    output logic [DATA_W-1:0]            fetch_data,
    output logic                         fetch_err
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int RAM_AW = $clog2(DEPTH);
    localparam int SHIFT  = byte_shift(DATA_W);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << SHIFT) - 64'd1);
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);

    imem_state_e       state_q;
    imem_state_e       state_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              overflow_q;
    logic              overflow_d;
    logic              done_q;
    logic              done_d;
    logic              fetch_valid_q;
    logic              fetch_valid_d;
    logic              fetch_err_q;
    logic              fetch_err_d;

    logic              load_ready_s;
    logic              accept_s;
    logic              store_s;
    logic [ADDR_W-1:0] index_s;
    logic [1:0]        err_cause_s;
    logic              err_s;
    logic              ram_re_s;
    logic [DATA_W-1:0] ram_rdata_s;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: load_start always (re)opens a session.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                end else if (load_valid && load_last) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_READY: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: ready is a pure decode of the state.
    always_comb begin
        load_ready_s = 1'b0;
        case (state_q)
            ST_LOAD:  load_ready_s = 1'b1;
            ST_IDLE:  load_ready_s = 1'b0;
            ST_READY: load_ready_s = 1'b0;
            default:  load_ready_s = 1'b0;
        endcase
    end

    // A word coinciding with load_start belongs to no session and is ignored.
    assign accept_s = load_ready_s & load_valid & ~load_start;
    assign store_s  = accept_s & (count_q < DEPTH_C);

    // Session bookkeeping: word count, sticky overflow, done flag.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        done_d     = done_q;
        if (load_start) begin
            count_d    = {CNT_W{1'b0}};
            overflow_d = 1'b0;
            done_d     = 1'b0;
        end else if (accept_s) begin
            if (store_s) begin
                count_d = count_q + CNT_W'(1);
            end else begin
                overflow_d = 1'b1;
            end
            if (load_last) begin
                done_d = 1'b1;
            end else begin
                done_d = done_q;
            end
        end else begin
            count_d    = count_q;
            overflow_d = overflow_q;
            done_d     = done_q;
        end
    end

    // Session bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= {CNT_W{1'b0}};
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    // Fetch checks; the range compare uses the whole index, so large
    // addresses whose upper bits are set are rejected rather than aliased.
    always_comb begin
        index_s     = fetch_addr >> SHIFT;
        err_cause_s = ERR_CAUSE_NONE;
        if (state_q != ST_READY) begin
            err_cause_s = ERR_CAUSE_STATE;
        end else if ((fetch_addr & ALIGN_MASK) != {ADDR_W{1'b0}}) begin
            err_cause_s = ERR_CAUSE_ALIGN;
        end else if (index_s >= ADDR_W'(count_q)) begin
            err_cause_s = ERR_CAUSE_RANGE;
        end else begin
            err_cause_s = ERR_CAUSE_NONE;
        end
    end

    assign err_s    = (err_cause_s != ERR_CAUSE_NONE);
    assign ram_re_s = fetch_en & ~err_s;

    // Fetch response next values; error flag holds while no request.
    always_comb begin
        fetch_valid_d = fetch_en;
        fetch_err_d   = fetch_err_q;
        if (fetch_en) begin
            fetch_err_d = err_s;
        end else begin
            fetch_err_d = fetch_err_q;
        end
    end

    // Fetch response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            fetch_valid_q <= fetch_valid_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (store_s),
        .waddr (count_q[RAM_AW-1:0]),
        .wdata (load_data),
        .re    (ram_re_s),
        .raddr (index_s[RAM_AW-1:0]),
        .rdata (ram_rdata_s)
    );

    assign load_ready    = load_ready_s;
    assign load_done     = done_q;
    assign load_overflow = overflow_q;
    assign loaded_words  = count_q;
    assign fetch_valid   = fetch_valid_q;
    assign fetch_err     = fetch_err_q;
    // A rejected fetch leaves the RAM read register untouched, so the zero
    // data on error comes from this mask.
    assign fetch_data    = fetch_err_q ? {DATA_W{1'b0}} : ram_rdata_s;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Randomised bench for imem_stream_loader against a queue-based model.
module tb_imem_stream_loader;
    import imem_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 32;

    logic          clk;
    logic          reset;
    logic          load_start;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          load_ready;
    logic          load_done;
    logic          load_overflow;
    logic [4:0]    loaded_words;
    logic          fetch_en;
    logic [AW-1:0] fetch_addr;
    logic          fetch_valid;
    logic [DW-1:0] fetch_data;
    logic          fetch_err;

    int n_checks;
    int n_fail;

    // Reference model: 0 idle, 1 loading, 2 loaded.
    int            m_mode;
    logic [DW-1:0] m_words[$];
    bit            m_ovf;
    bit            m_fv;
    bit            m_fe;
    logic [DW-1:0] m_fd;

    imem_stream_loader #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .load_start    (load_start),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_last     (load_last),
        .load_ready    (load_ready),
        .load_done     (load_done),
        .load_overflow (load_overflow),
        .loaded_words  (loaded_words),
        .fetch_en      (fetch_en),
        .fetch_addr    (fetch_addr),
        .fetch_valid   (fetch_valid),
        .fetch_data    (fetch_data),
        .fetch_err     (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_words.delete();
        m_ovf = 1'b0;
        m_fv  = 1'b0;
        m_fe  = 1'b0;
        m_fd  = '0;
    endtask

    // One clock edge of the reference behaviour, using pre-edge model state.
    task automatic model_step(input bit st, input bit v, input logic [DW-1:0] d,
                              input bit l, input bit fen, input logic [AW-1:0] fa);
        logic [1:0] cause;
        m_fv = fen;
        if (fen) begin
            if (m_mode != 2)                         cause = ERR_CAUSE_STATE;
            else if (fa % 4 != 0)                    cause = ERR_CAUSE_ALIGN;
            else if ((fa / 4) >= m_words.size())     cause = ERR_CAUSE_RANGE;
            else                                     cause = ERR_CAUSE_NONE;
            m_fe = (cause != ERR_CAUSE_NONE);
            m_fd = m_fe ? '0 : m_words[fa / 4];
        end
        if (st) begin
            m_words.delete();
            m_ovf  = 1'b0;
            m_mode = 1;
        end else if (m_mode == 1 && v) begin
            if (m_words.size() < DEPTH) m_words.push_back(d);
            else                        m_ovf = 1'b1;
            if (l) m_mode = 2;
        end
    endtask

    task automatic check_all();
        check("load_ready",    64'(load_ready),    64'(m_mode == 1));
        check("load_done",     64'(load_done),     64'(m_mode == 2));
        check("load_overflow", 64'(load_overflow), 64'(m_ovf));
        check("loaded_words",  64'(loaded_words),  64'(m_words.size()));
        check("fetch_valid",   64'(fetch_valid),   64'(m_fv));
        check("fetch_err",     64'(fetch_err),     64'(m_fe));
        check("fetch_data",    64'(fetch_data),    64'(m_fd));
    endtask

    // Drive one cycle of inputs, step the model at the edge, check after it.
    task automatic cyc(input bit st, input bit v, input logic [DW-1:0] d, input bit l,
                       input bit fen, input logic [AW-1:0] fa);
        @(negedge clk);
        load_start = st; load_valid = v; load_data = d; load_last = l;
        fetch_en = fen; fetch_addr = fa;
        @(posedge clk);
        model_step(st, v, d, l, fen, fa);
        #1;
        check_all();
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic fetch(input logic [AW-1:0] fa);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, fa);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        reset = 1'b1;
        load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        fetch_en = 1'b0; fetch_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Basic load of four words, then aligned fetches.
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 32'h11, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 32'h22, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 32'h33, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 32'h0);   // fetch in last handshake
        check("last_cycle_err", 64'(fetch_err), 64'd1);
        check("words4", 64'(loaded_words), 64'd4);
        fetch(32'h0);  check("fd_0x0", 64'(fetch_data), 64'h11);
        fetch(32'h4);  check("fd_0x4", 64'(fetch_data), 64'h22);
        fetch(32'h8);  check("fd_0x8", 64'(fetch_data), 64'h33);
        fetch(32'hC);  check("fd_0xC", 64'(fetch_data), 64'h44);
        fetch(32'h10); check("range_err", 64'(fetch_err), 64'd1);
        fetch(32'h6);  check("align_err", 64'(fetch_err), 64'd1);
        fetch(32'h8000_0000); check("high_err", 64'(fetch_err), 64'd1);
        idle_cyc();
        check("hold_err", 64'(fetch_err), 64'd1);

        // Overflow: 18 words into 16 entries, then restart served in READY.
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'h4);
        check("start_fetch_served", 64'(fetch_data), 64'h22);
        for (int i = 0; i < 18; i++) cyc(1'b0, 1'b1, 32'(i), (i == 17), 1'b0, '0);
        check("ovf", 64'(load_overflow), 64'd1);
        check("words16", 64'(loaded_words), 64'd16);
        fetch(32'h3C); check("fd_0x3C", 64'(fetch_data), 64'd15);
        fetch(32'h40); check("ovf_range_err", 64'(fetch_err), 64'd1);

        // Restart mid-stream: the word with load_start is not stored.
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 32'hA0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 32'hA1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b1, 32'hA2, 1'b0, 1'b0, '0);
        check("restart_count", 64'(loaded_words), 64'd0);
        cyc(1'b0, 1'b1, 32'hB0, 1'b0, 1'b0, '0);
        check("done_low", 64'(load_done), 64'd0);
        cyc(1'b0, 1'b1, 32'hB1, 1'b1, 1'b0, '0);
        fetch(32'h0); check("restart_fd", 64'(fetch_data), 64'hB0);

        // Back-to-back fetches.
        fetch(32'h0); fetch(32'h4); fetch(32'h8);
        check("b2b_err", 64'(fetch_err), 64'd1);

        // Asynchronous reset between edges in the middle of a load.
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 32'h55, 1'b0, 1'b1, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        check("async_ready", 64'(load_ready), 64'd0);
        reset = 1'b0;
        fetch(32'h0); check("post_reset_err", 64'(fetch_err), 64'd1);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            bit            st;
            bit            v;
            bit            l;
            bit            fen;
            logic [AW-1:0] fa;
            st  = ($urandom_range(0, 39) == 0);
            v   = ($urandom_range(0, 9) < 7);
            l   = ($urandom_range(0, 11) == 0);
            fen = ($urandom_range(0, 9) < 6);
            fa  = AW'($urandom_range(0, 80));
            if ($urandom_range(0, 15) == 0) fa = fa | 32'h0100_0000;
            cyc(st, v, DW'($urandom), l, fen, fa);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
